add_sched: RTL and testbench



---
 rtl/add_sched.sv | 178 +++++++++++++++++
 tb/tb_add_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_sched.sv
// add_sched: round-robin scheduler that time-shares one SLICE-bit adder for WIDTH-bit adds.
// Defining ADD_SCHED_OVF_EN adds the registered signed-overflow output rsp_ovf.
module add_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
`ifdef ADD_SCHED_OVF_EN
    output logic                    rsp_ovf,
`endif
    output logic [SLICE-1:0]        add_a,
    output logic [SLICE-1:0]        add_b,
    output logic                    add_c0,
    input  logic [SLICE:0]          add_result
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDW    = $clog2(NREQ);
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   grant_id;
    logic             grant_vld;
    int unsigned      srch_idx;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_cin;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic             last_slice;

    assign last_slice = (k_q == KW'(NSLICE - 1));

    // First valid requester at or above rr_ptr, wrapping around
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        srch_idx  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            srch_idx = (32'(rr_ptr_q) + i) % NREQ;
            if (!grant_vld && req_valid[IDW'(srch_idx)]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(srch_idx);
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_a   = req_a[i*WIDTH +: WIDTH];
                sel_b   = req_b[i*WIDTH +: WIDTH];
                sel_cin = req_cin[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_c0    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rst_n && grant_vld) begin
                    req_ready = NREQ'(1) << grant_id;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                for (int unsigned s = 0; s < NSLICE; s++) begin
                    if (k_q == KW'(s)) begin
                        add_a = a_q[s*SLICE +: SLICE];
                        add_b = b_q[s*SLICE +: SLICE];
                    end
                end
                add_c0 = carry_q;
                if (last_slice) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, slice accumulation and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        carry_q <= sel_cin;
                        id_q    <= grant_id;
                        k_q     <= '0;
                    end
                end
                S_CALC: begin
                    for (int unsigned s = 0; s < NSLICE; s++) begin
                        if (k_q == KW'(s)) begin
                            sum_q[s*SLICE +: SLICE] <= add_result[SLICE-1:0];
                        end
                    end
                    carry_q <= add_result[SLICE];
                    k_q     <= k_q + KW'(1);
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rr_ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state_q == S_DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;

`ifdef ADD_SCHED_OVF_EN
    logic ovf_q;

    // Carry into the MSB (a^b^sum) xor the final carry-out, taken with the last slice
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_CALC && last_slice) begin
            ovf_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ add_result[SLICE-1] ^ add_result[SLICE];
        end
    end

    assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_sched.sv
// Directed self-checking bench for add_sched with a behavioural combinational slice adder.
module tb_add_sched;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned SLICE = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_a, req_b;
    logic [NREQ-1:0]         req_cin;
    logic                    rsp_valid, rsp_ready;
    logic [1:0]              rsp_id;
    logic [WIDTH-1:0]        rsp_sum;
    logic                    rsp_cout;
`ifdef ADD_SCHED_OVF_EN
    logic                    rsp_ovf;
`endif
    logic [SLICE-1:0]        add_a, add_b;
    logic                    add_c0;
    logic [SLICE:0]          add_result;

    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    int n_assert = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] rr_sum  [NREQ] = '{64'h1234_5678_9ABC_DF00, 64'h0000_0001_0000_0001,
                                         64'h0000_0000_0000_0000, 64'h0000_0004_0000_0006};
    logic             rr_cout [NREQ] = '{1'b0, 1'b1, 1'b1, 1'b0};

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
    assign add_result = {1'b0, add_a} + {1'b0, add_b} + {{SLICE{1'b0}}, add_c0};

    always #5 clk = ~clk;

    add_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
`ifdef ADD_SCHED_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .add_a      (add_a),
        .add_b      (add_b),
        .add_c0     (add_c0),
        .add_result (add_result)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(rsp_id),    64'd0);
        check("rst_rsp_sum",   rsp_sum,        64'd0);
        check("rst_rsp_cout",  64'(rsp_cout),  64'd0);
        check("rst_add_a",     64'(add_a),     64'd0);
        check("rst_add_b",     64'(add_b),     64'd0);
        check("rst_add_c0",    64'(add_c0),    64'd0);
`ifdef ADD_SCHED_OVF_EN
        check("rst_rsp_ovf",   64'(rsp_ovf),   64'd0);
`endif
        rst_n = 1'b1;

        // Single request with carry crossing the slice boundary
        op_a[0]   = 64'h0000_0000_FFFF_FFFF;
        op_b[0]   = 64'h1;
        req_valid = 4'b0001;
        #1 check("A_grant", 64'(req_ready), 64'h1);
        tick;
        req_valid = '0;
        check("A_k0_add_a",  64'(add_a),     64'hFFFF_FFFF);
        check("A_k0_add_b",  64'(add_b),     64'h1);
        check("A_k0_add_c0", 64'(add_c0),    64'd0);
        check("A_k0_valid",  64'(rsp_valid), 64'd0);
        tick;
        check("A_k1_add_a",  64'(add_a),     64'd0);
        check("A_k1_add_c0", 64'(add_c0),    64'd1);
        check("A_k1_valid",  64'(rsp_valid), 64'd0);
        tick;
        check("A_valid", 64'(rsp_valid), 64'd1);
        check("A_sum",   rsp_sum,        64'h0000_0001_0000_0000);
        check("A_cout",  64'(rsp_cout),  64'd0);
        check("A_id",    64'(rsp_id),    64'd0);
        check("A_done_add_a", 64'(add_a), 64'd0);
        rsp_ready = 1'b1;
        tick;
        check("A_after_valid", 64'(rsp_valid), 64'd0);

        // Full-width carry-out from requester 2 (search starts at 1)
        op_a[2]   = 64'hFFFF_FFFF_FFFF_FFFF;
        op_b[2]   = 64'h0;
        req_cin   = 4'b0100;
        req_valid = 4'b0100;
        #1 check("B_grant", 64'(req_ready), 64'h4);
        tick;
        req_valid = '0;
        tick;
        tick;
        check("B_valid", 64'(rsp_valid), 64'd1);
        check("B_sum",   rsp_sum,        64'd0);
        check("B_cout",  64'(rsp_cout),  64'd1);
        check("B_id",    64'(rsp_id),    64'd2);
        tick;
        req_cin = '0;

`ifdef ADD_SCHED_OVF_EN
        op_a[3]   = 64'h7FFF_FFFF_FFFF_FFFF;
        op_b[3]   = 64'h1;
        req_valid = 4'b1000;
        #1 check("V_grant", 64'(req_ready), 64'h8);
        tick;
        req_valid = '0;
        tick;
        tick;
        check("V_sum",  rsp_sum,       64'h8000_0000_0000_0000);
        check("V_cout", 64'(rsp_cout), 64'd0);
        check("V_ovf",  64'(rsp_ovf),  64'd1);
        check("V_id",   64'(rsp_id),   64'd3);
        tick;
`endif

        // Backpressure: requester 0 wins by wrap-around, requester 1 waits
        rsp_ready = 1'b0;
        op_a[0]   = 64'h5;
        op_b[0]   = 64'h3;
        op_a[1]   = 64'h0000_0002_0000_0010;
        op_b[1]   = 64'h20;
        req_valid = 4'b0011;
        #1 check("C_grant", 64'(req_ready), 64'h1);
        tick;
        req_valid = 4'b0010;
        check("C_calc_ready", 64'(req_ready), 64'd0);
        tick;
        tick;
        check("C_valid", 64'(rsp_valid), 64'd1);
        check("C_sum",   rsp_sum,        64'h8);
        check("C_id",    64'(rsp_id),    64'd0);
        for (int c = 0; c < 5; c++) begin
            tick;
            check("C_hold_valid", 64'(rsp_valid), 64'd1);
            check("C_hold_sum",   rsp_sum,        64'h8);
            check("C_hold_id",    64'(rsp_id),    64'd0);
            check("C_hold_cout",  64'(rsp_cout),  64'd0);
            check("C_hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick;
        check("C_after_valid", 64'(rsp_valid), 64'd0);
        check("C_next_grant",  64'(req_ready), 64'h2);

        // Reset during the second CALC cycle drops the operation
        tick;
        req_valid = '0;
        check("R_k0_add_a", 64'(add_a), 64'h10);
        tick;
        check("R_k1_add_a", 64'(add_a), 64'h2);
        rst_n = 1'b0;
        tick;
        check("R_valid", 64'(rsp_valid), 64'd0);
        check("R_sum",   rsp_sum,        64'd0);
        check("R_id",    64'(rsp_id),    64'd0);
        check("R_add_a", 64'(add_a),     64'd0);
        rst_n = 1'b1;
        tick;
        check("R_no_rsp", 64'(rsp_valid), 64'd0);

        // Round-robin with all requesters continuously valid
        op_a[0] = 64'h0123_4567_89AB_CDEF;  op_b[0] = 64'h1111_1111_1111_1111;
        op_a[1] = 64'h8000_0000_8000_0000;  op_b[1] = 64'h8000_0000_8000_0000;
        op_a[2] = 64'hFFFF_FFFF_0000_0000;  op_b[2] = 64'h0000_0000_FFFF_FFFF;
        op_a[3] = 64'h0000_0001_0000_0002;  op_b[3] = 64'h0000_0003_0000_0004;
        req_cin   = 4'b0110;
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int r;
            r = n % 4;
            #1 check("D_grant", 64'(req_ready), 64'(1) << r);
            tick;
            tick;
            tick;
            check("D_valid", 64'(rsp_valid), 64'd1);
            check("D_id",    64'(rsp_id),    64'(r));
            check("D_sum",   rsp_sum,        rr_sum[r]);
            check("D_cout",  64'(rsp_cout),  64'(rr_cout[r]));
            tick;
        end
        req_valid = '0;
        tick;
        check("D_idle_valid", 64'(rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
